// File: rtl/oc8051_icache_refill.sv
// Instruction-cache line refill engine: fetches one 4-word line over Wishbone,
// writes it into the cache RAM and validates the line's tag when complete.
module oc8051_icache_refill #(
  parameter int ADR_WIDTH = 7,
  parameter int LINE_BITS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_i,
  input  logic [15:0]                    miss_adr_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [15:0]                    wb_adr_o,
  output logic                           wb_cyc_o,
  output logic                           wb_stb_o,
  input  logic [31:0]                    wb_dat_i,
  input  logic                           wb_ack_i,
  input  logic                           wb_err_i,
  output logic [ADR_WIDTH-1:0]           ram_adr_o,
  output logic [31:0]                    ram_dat_o,
  output logic                           ram_wr_o,
  output logic [ADR_WIDTH-LINE_BITS-1:0] tag_adr_o,
  output logic [13-ADR_WIDTH:0]          tag_dat_o,
  output logic                           tag_vld_o,
  output logic                           tag_wr_o
);

  localparam int IW = ADR_WIDTH - LINE_BITS;  // line index width
  localparam int TW = 14 - ADR_WIDTH;         // tag width
  localparam int BW = 14 - LINE_BITS;         // line base (word address without offset)
  localparam logic [LINE_BITS-1:0] LAST_WORD = '1;

  typedef enum logic [1:0] {IDLE, FETCH, TAG} state_t;

  state_t               state, state_n;
  logic [LINE_BITS-1:0] cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [TW-1:0]        tag, tag_n;
  logic [BW-1:0]        base, base_n;

  logic                 busy_n, done_n, err_n, cyc_n, stb_n;
  logic [15:0]          wb_adr_n;
  logic [ADR_WIDTH-1:0] ram_adr_n;
  logic [31:0]          ram_dat_n;
  logic                 ram_wr_n, tag_vld_n, tag_wr_n;
  logic [IW-1:0]        tag_adr_n;
  logic [TW-1:0]        tag_dat_n;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch can be inferred.
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    tag_n     = tag;
    base_n    = base;
    busy_n    = busy_o;
    cyc_n     = wb_cyc_o;
    stb_n     = wb_stb_o;
    wb_adr_n  = wb_adr_o;
    ram_adr_n = ram_adr_o;
    ram_dat_n = ram_dat_o;
    tag_adr_n = tag_adr_o;
    tag_dat_n = tag_dat_o;
    done_n    = 1'b0;
    err_n     = 1'b0;
    ram_wr_n  = 1'b0;
    tag_wr_n  = 1'b0;
    tag_vld_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (miss_i) begin
          state_n   = FETCH;
          cnt_n     = '0;
          idx_n     = miss_adr_i[ADR_WIDTH+1:LINE_BITS+2];
          tag_n     = miss_adr_i[15:ADR_WIDTH+2];
          base_n    = miss_adr_i[15:LINE_BITS+2];
          busy_n    = 1'b1;
          cyc_n     = 1'b1;
          stb_n     = 1'b1;
          wb_adr_n  = {miss_adr_i[15:LINE_BITS+2], {LINE_BITS{1'b0}}, 2'b00};
          // Invalidate the line first so a partial fill can never hit.
          tag_wr_n  = 1'b1;
          tag_adr_n = miss_adr_i[ADR_WIDTH+1:LINE_BITS+2];
          tag_dat_n = miss_adr_i[15:ADR_WIDTH+2];
        end
      end

      FETCH: begin
        if (wb_err_i) begin
          state_n = IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          err_n   = 1'b1;
        end else if (wb_ack_i) begin
          ram_wr_n  = 1'b1;
          ram_adr_n = {idx, cnt};
          ram_dat_n = wb_dat_i;
          cnt_n     = cnt + LINE_BITS'(1);
          if (cnt == LAST_WORD) begin
            state_n   = TAG;
            cyc_n     = 1'b0;
            stb_n     = 1'b0;
            tag_wr_n  = 1'b1;
            tag_vld_n = 1'b1;
            tag_adr_n = idx;
            tag_dat_n = tag;
            done_n    = 1'b1;
          end else begin
            wb_adr_n = {base, cnt + LINE_BITS'(1), 2'b00};
          end
        end
      end

      TAG: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      tag       <= '0;
      base      <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      wb_adr_o  <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      ram_adr_o <= '0;
      ram_dat_o <= '0;
      ram_wr_o  <= 1'b0;
      tag_adr_o <= '0;
      tag_dat_o <= '0;
      tag_vld_o <= 1'b0;
      tag_wr_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      tag       <= tag_n;
      base      <= base_n;
      busy_o    <= busy_n;
      done_o    <= done_n;
      err_o     <= err_n;
      wb_adr_o  <= wb_adr_n;
      wb_cyc_o  <= cyc_n;
      wb_stb_o  <= stb_n;
      ram_adr_o <= ram_adr_n;
      ram_dat_o <= ram_dat_n;
      ram_wr_o  <= ram_wr_n;
      tag_adr_o <= tag_adr_n;
      tag_dat_o <= tag_dat_n;
      tag_vld_o <= tag_vld_n;
      tag_wr_o  <= tag_wr_n;
    end
  end

endmodule

// File: tb/tb_oc8051_icache_refill.sv
// Scoreboard bench for oc8051_icache_refill: a Wishbone responder predicts each
// refill's RAM/tag/done/err events with cycle stamps; a monitor pops and compares.
module tb_oc8051_icache_refill;

  localparam int ADR_WIDTH = 7;
  localparam int LINE_BITS = 2;
  localparam int WORDS     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_i;
  logic [15:0] miss_adr_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] wb_adr_o;
  logic        wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic [6:0]  ram_adr_o;
  logic [31:0] ram_dat_o;
  logic        ram_wr_o;
  logic [4:0]  tag_adr_o;
  logic [6:0]  tag_dat_o;
  logic        tag_vld_o, tag_wr_o;

  oc8051_icache_refill #(.ADR_WIDTH(ADR_WIDTH), .LINE_BITS(LINE_BITS)) dut (
    .clk(clk), .rst(rst), .miss_i(miss_i), .miss_adr_i(miss_adr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o), .ram_wr_o(ram_wr_o),
    .tag_adr_o(tag_adr_o), .tag_dat_o(tag_dat_o), .tag_vld_o(tag_vld_o),
    .tag_wr_o(tag_wr_o)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_RAM, EV_TAG, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          stamp;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        vld;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc_cnt = 0;     // number of rising edges seen so far
  int  ready_edge = 0;  // earliest edge at which the model says a miss can be accepted

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc_cnt);
    end
  endtask

  // Reference model: plain address arithmetic for the line geometry.
  function automatic int line_index(input logic [15:0] a);
    return (int'(a) >> (LINE_BITS + 2)) % (1 << (ADR_WIDTH - LINE_BITS));
  endfunction
  function automatic int line_tag(input logic [15:0] a);
    return int'(a) >> (ADR_WIDTH + 2);
  endfunction
  function automatic int bus_addr(input logic [15:0] a, input int w);
    return (int'(a) / (WORDS * 4)) * (WORDS * 4) + w * 4;
  endfunction

  function automatic ev_t mk(input ev_kind_t k, input int st, input int adr,
                             input logic [31:0] dat, input logic vld);
    ev_t e;
    e.kind = k; e.stamp = st; e.adr = adr; e.dat = dat; e.vld = vld;
    return e;
  endfunction

  task automatic observe(input ev_kind_t k, input logic [31:0] adr,
                         input logic [31:0] dat, input logic vld);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got %s adr %0h dat %0h expected none (cycle %0d)",
               k.name(), adr, dat, cyc_cnt);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    check("event_cycle", cyc_cnt, e.stamp);
    if (k == EV_RAM) begin
      check("ram_adr", adr, e.adr);
      check("ram_dat", dat, e.dat);
    end
    if (k == EV_TAG) begin
      check("tag_adr", adr, e.adr);
      check("tag_vld", vld, e.vld);
      if (e.vld) check("tag_dat", dat, e.dat);
    end
  endtask

  // Monitor: one pop per output event, in a fixed per-cycle order.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_wr_o) observe(EV_RAM, 32'(ram_adr_o), ram_dat_o, 1'b0);
      if (tag_wr_o) observe(EV_TAG, 32'(tag_adr_o), 32'(tag_dat_o), tag_vld_o);
      if (done_o) begin
        observe(EV_DONE, 0, 0, 1'b0);
        check("busy_at_done", busy_o, 1'b1);
        check("cyc_at_done", wb_cyc_o, 1'b0);
      end
      if (err_o) begin
        observe(EV_ERR, 0, 0, 1'b0);
        check("busy_at_err", busy_o, 1'b0);
        check("cyc_at_err", wb_cyc_o, 1'b0);
      end
    end
  end

  task automatic bus_state(input string name, input logic [15:0] adr, input int w);
    check({name, "_cyc"}, wb_cyc_o, 1'b1);
    check({name, "_stb"}, wb_stb_o, 1'b1);
    check({name, "_busy"}, busy_o, 1'b1);
    check({name, "_wb_adr"}, wb_adr_o, 64'(bus_addr(adr, w)));
  endtask

  // One refill as seen by the bus slave. wait_mode<0: random 0..3 wait states per word.
  // err_word: word on which wb_err_i is returned (-1 none). abort_after: reset after
  // that many acks (0 none). Called and returns on a falling edge.
  task automatic refill(input logic [15:0] adr, input int wait_mode, input int err_word,
                        input bit hold, input int abort_after, input bit fixed_data);
    int acc, waits;
    logic [31:0] dat;
    miss_adr_i = adr;
    miss_i     = 1'b1;
    acc = (cyc_cnt + 1 > ready_edge) ? cyc_cnt + 1 : ready_edge;
    exp_q.push_back(mk(EV_TAG, acc, line_index(adr), 0, 1'b0));
    while (cyc_cnt < acc) @(negedge clk);
    if (!hold) begin
      miss_i     = ($urandom_range(1, 0) == 1);  // ignored while busy
      miss_adr_i = 16'($urandom);
    end
    for (int w = 0; w < WORDS; w++) begin
      waits = (wait_mode < 0) ? $urandom_range(3, 0) : wait_mode;
      for (int i = 0; i < waits; i++) begin
        wb_ack_i = 1'b0;
        bus_state("wait", adr, w);
        @(negedge clk);
      end
      bus_state("ack", adr, w);
      dat = fixed_data ? 32'hA0 + 32'(w) : $urandom;
      wb_dat_i = dat;
      if (w == err_word) begin
        wb_err_i = 1'b1;
        wb_ack_i = ($urandom_range(1, 0) == 1);
        exp_q.push_back(mk(EV_ERR, cyc_cnt + 1, 0, 0, 1'b0));
        ready_edge = cyc_cnt + 2;
        @(negedge clk);
        wb_err_i = 1'b0;
        wb_ack_i = 1'b0;
        if (!hold) miss_i = 1'b0;
        return;
      end
      wb_ack_i = 1'b1;
      exp_q.push_back(mk(EV_RAM, cyc_cnt + 1, line_index(adr) * WORDS + w, dat, 1'b0));
      if (w == WORDS - 1) begin
        exp_q.push_back(mk(EV_TAG, cyc_cnt + 1, line_index(adr), 32'(line_tag(adr)), 1'b1));
        exp_q.push_back(mk(EV_DONE, cyc_cnt + 1, 0, 0, 1'b0));
        ready_edge = cyc_cnt + 3;
      end
      @(negedge clk);
      wb_ack_i = 1'b0;
      if (abort_after == w + 1) begin
        #1 rst = 1'b1;
        #1;
        check("async_rst_cyc", wb_cyc_o, 1'b0);
        check("async_rst_stb", wb_stb_o, 1'b0);
        check("async_rst_busy", busy_o, 1'b0);
        check("async_rst_done", done_o, 1'b0);
        miss_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ready_edge = cyc_cnt + 1;
        return;
      end
    end
    if (!hold) miss_i = 1'b0;
  endtask

  // Idle cycles with stray bus responses, which must be ignored outside FETCH.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      wb_ack_i = ($urandom_range(1, 0) == 1);
      wb_err_i = ($urandom_range(3, 0) == 0);
      wb_dat_i = $urandom;
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; miss_i = 1'b0; miss_adr_i = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    @(negedge clk);
    miss_i = 1'b1;  // must be ignored while in reset
    @(negedge clk);
    check("rst_busy", busy_o, 1'b0);
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_wb_adr", wb_adr_o, 16'h0000);
    check("rst_ram_wr", ram_wr_o, 1'b0);
    check("rst_tag_wr", tag_wr_o, 1'b0);
    check("rst_done_err", {done_o, err_o, tag_vld_o}, 3'b000);
    miss_i = 1'b0;
    rst    = 1'b0;
    ready_edge = cyc_cnt + 1;
    @(negedge clk);

    refill(16'h1234, 0, -1, 1'b0, 0, 1'b1);   // back-to-back acks
    gap(3);
    refill(16'h1234, 2, -1, 1'b0, 0, 1'b1);   // two wait states per word
    gap(2);
    refill(16'h1234, 0, 2, 1'b0, 0, 1'b0);    // bus error on third word
    check("busy_after_err", busy_o, 1'b0);
    gap(2);
    refill(16'h2468, 1, -1, 1'b1, 0, 1'b0);   // miss held high: back-to-back refills
    refill(16'h5678, 0, -1, 1'b0, 0, 1'b0);
    gap(2);
    refill(16'h1234, 0, -1, 1'b0, 2, 1'b0);   // reset after second ack
    refill(16'h1234, 0, -1, 1'b0, 0, 1'b0);
    gap(1);
    refill(16'hFFFC, 0, -1, 1'b0, 0, 1'b0);   // top of address space
    gap(1);
    for (int t = 0; t < 40; t++) begin
      refill(16'($urandom), -1, ($urandom_range(4, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
             ($urandom_range(5, 0) == 0), 0, 1'b0);
      if (miss_i == 1'b0) gap($urandom_range(2, 0));
    end
    miss_i = 1'b0;
    repeat (8) @(negedge clk);
    check("final_busy", busy_o, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
